spi_draw_sequencer: RTL and testbench
=====================================

Name: spi_draw_sequencer

Overview:
- Sits between the SPI byte receiver and the framebuffer write port.
- Assembles the incoming byte stream into configuration packets (1 byte) and position packets (2 bytes: x then y).
- Holds the current brush and colour state.
- Issues one draw request per complete position packet, using a req/ack handshake with the framebuffer writer.
- Recovers framing after timeouts or drops and keeps a drop counter.

Parameters:
- TIMEOUT_CYCLES, 4096: idle cycles allowed between the x and y bytes of a position packet before the partial packet is discarded; counter width is $clog2(TIMEOUT_CYCLES).
- DEFAULT_COLOR, 3'b010: colour loaded at reset (green).
- DEFAULT_BRUSH, 1'b1: brush state loaded at reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- byteValid  in  1  one-cycle strobe; byteData is valid this cycle.
- byteData  in  8  received SPI byte.
- drawAck  in  1  framebuffer writer accepts the request; only meaningful while drawReq=1.
- drawReq  out  1  draw request, held until acknowledged.
- drawX  out  8  x coordinate of the pending draw.
- drawY  out  8  y coordinate of the pending draw.
- drawColor  out  3  colour snapshot for the pending draw.
- drawBrush  out  1  brush snapshot for the pending draw.
- color  out  3  current colour register.
- brush  out  1  current brush register.
- configUpdated  out  1  one-cycle pulse after a config byte is applied.
- dropCount  out  8  saturating count of discarded packets.

Behaviour:
- Reset values:
  - FSM=IDLE; drawReq=0; drawX=drawY=0; drawColor=DEFAULT_COLOR; drawBrush=DEFAULT_BRUSH.
  - color=DEFAULT_COLOR; brush=DEFAULT_BRUSH; configUpdated=0; dropCount=0; skipNext=0; timeout counter=0.
- Config byte: byteData[7:5]==3'b111.
  - Accepted whenever it arrives as a packet's first byte, in any state, including WAIT_ACK.
  - Next cycle: brush=byteData[4], color=byteData[2:0], configUpdated=1 for exactly one cycle.
  - byteData[3] is ignored.
- FSM states: IDLE, HAVE_X, WAIT_ACK.
- IDLE:
  - Non-config byte with skipNext=0: latch it as x, clear the timeout counter, go to HAVE_X.
  - Byte with skipNext=1: discard it and clear skipNext. The byte is not counted.
- HAVE_X:
  - byteValid: latch y; this byte is never interpreted as config, so 111xxxxx is a valid y.
  - On that edge: drawX=x, drawY=y, drawColor=color, drawBrush=brush, drawReq=1, go to WAIT_ACK. Latency is byte-in to drawReq high = 1 cycle.
  - No byte while the counter reaches TIMEOUT_CYCLES-1: discard x, dropCount+1, go to IDLE.
- WAIT_ACK:
  - drawReq and all draw* outputs stay stable until drawAck=1 is sampled.
  - On the ack edge: drawReq=0, go to IDLE.
  - A byteValid in the ack cycle is processed under IDLE rules on the same edge, so it is not lost (e.g. it goes straight to HAVE_X).
  - A non-config byte without ack: dropped, dropCount+1, skipNext=1 so the orphaned y byte is also discarded.
  - A config byte without ack: applied to color/brush only; the draw* snapshot is unchanged.
- skipNext:
  - Also cleared by the timeout counter expiring. The counter runs while skipNext=1 and no byte arrives.
  - That expiry does not increment dropCount.
- dropCount: saturates at 255 and never wraps.
- Simultaneous events: config application and a dropCount increment never coincide on one byte. Ack and a byte in the same cycle are handled as described above.
- Reset mid-handshake: drawReq drops immediately (asynchronous); the pending draw is lost and not counted.

Test Plan:
1. Reset, then bytes 0x05 then 0x09 -> drawReq=1 one cycle after the second byte with drawX=5, drawY=9, drawColor=3'b010, drawBrush=1. Ack 3 cycles later -> drawReq=0 next cycle.
2. Byte 0xF3 -> next cycle color=3'b011, brush=1, configUpdated high exactly 1 cycle. Then 0xE0 -> color=0, brush=0. Following packet 0x10, 0xE7 -> drawY=0xE7, drawColor=0.
3. Byte 0x20 then no byte for TIMEOUT_CYCLES -> FSM IDLE, dropCount=1, no drawReq. Then 0x01, 0x02 -> draw (1,2).
4. Hold drawAck=0 and send packet (3,4) then 0x07, 0x08, 0xF5 -> drawX/Y stay (3,4); dropCount=1; 0x08 silently skipped; color=3'b101. Ack -> drawReq=0. Next packet 0x0A, 0x0B -> draw (10,11) with drawColor=3'b101.
5. Pending request; assert drawAck in the same cycle as byte 0x30 -> request retires, FSM goes to HAVE_X. 0x31 -> new draw (0x30,0x31).
6. Force 260 timeouts -> dropCount=255. Assert reset while drawReq=1 -> drawReq=0 asynchronously; all outputs at reset values.

Source files
------------

// File: rtl/spi_draw_sequencer.sv
// ---------------------------------------------------------------------------
// spi_draw_sequencer
//
// Purpose:
//   Turns the SPI receiver's byte stream into draw requests for the
//   framebuffer writer.
//   - A byte of the form 111bxccc is a configuration packet. It updates
//     brush (b) and colour (ccc).
//   - Any other first byte starts a two-byte position packet (x, then y).
//   - Every complete position packet issues one draw request on a req/ack
//     handshake.
//   The block also recovers framing after timeouts or dropped packets and
//   counts discarded packets.
//
// Handshake (drawReq/drawAck):
//   drawReq rises together with a stable drawX/drawY/drawColor/drawBrush
//   snapshot. Request and snapshot hold until drawAck=1 is sampled on a
//   rising clock edge, and drawReq falls on that edge. drawAck is ignored
//   while drawReq=0.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   byteValid     in   one-cycle strobe qualifying byteData
//   byteData[7:0] in   received SPI byte
//   drawAck       in   framebuffer writer accepts the pending request
//   drawReq       out  pending draw request
//   drawX/drawY   out  coordinates of the pending draw
//   drawColor     out  colour snapshot of the pending draw
//   drawBrush     out  brush snapshot of the pending draw
//   color/brush   out  current colour / brush registers
//   configUpdated out  one-cycle pulse after a config byte is applied
//   dropCount     out  saturating count of discarded packets
//   dbgState      out  FSM state (0=IDLE, 1=HAVE_X, 2=WAIT_ACK)
// ---------------------------------------------------------------------------
module spi_draw_sequencer #(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [2:0]  DEFAULT_COLOR  = 3'b010,
  parameter logic        DEFAULT_BRUSH  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byteValid,
  input  logic [7:0] byteData,
  input  logic       drawAck,
  output logic       drawReq,
  output logic [7:0] drawX,
  output logic [7:0] drawY,
  output logic [2:0] drawColor,
  output logic       drawBrush,
  output logic [2:0] color,
  output logic       brush,
  output logic       configUpdated,
  output logic [7:0] dropCount,
  output logic [1:0] dbgState
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HAVE_X   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      x_q, x_d;
  logic            draw_req_q, draw_req_d;
  logic [7:0]      draw_x_q, draw_x_d;
  logic [7:0]      draw_y_q, draw_y_d;
  logic [2:0]      draw_color_q, draw_color_d;
  logic            draw_brush_q, draw_brush_d;
  logic [2:0]      color_q, color_d;
  logic            brush_q, brush_d;
  logic            cfg_upd_q, cfg_upd_d;
  logic [7:0]      drop_q, drop_d;
  logic            skip_q, skip_d;
  logic [CW-1:0]   tmo_q, tmo_d;

  logic            is_cfg;
  logic            tmo_hit;
  logic [7:0]      drop_inc;
  logic            idle_rules;

  assign is_cfg   = (byteData[7:5] == 3'b111);
  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign drop_inc = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  // An ack retires the request and frees the FSM on the same edge, so a byte
  // arriving in the ack cycle is handled exactly as if we were already idle.
  assign idle_rules = (state_q == ST_IDLE) ||
                      ((state_q == ST_WAIT_ACK) && drawAck);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    draw_req_d   = draw_req_q;
    draw_x_d     = draw_x_q;
    draw_y_d     = draw_y_q;
    draw_color_d = draw_color_q;
    draw_brush_d = draw_brush_q;
    color_d      = color_q;
    brush_d      = brush_q;
    cfg_upd_d    = 1'b0;
    drop_d       = drop_q;
    skip_d       = skip_q;
    tmo_d        = tmo_q;

    case (state_q)
      ST_HAVE_X: begin
        if (byteValid) begin
          // Second byte is always y, even if it looks like a config byte.
          draw_x_d     = x_q;
          draw_y_d     = byteData;
          draw_color_d = color_q;
          draw_brush_d = brush_q;
          draw_req_d   = 1'b1;
          state_d      = ST_WAIT_ACK;
        end else if (tmo_hit) begin
          drop_d  = drop_inc;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end

      ST_IDLE, ST_WAIT_ACK: begin
        if (state_q == ST_WAIT_ACK && drawAck) begin
          draw_req_d = 1'b0;
          state_d    = ST_IDLE;
        end
        if (byteValid) begin
          if (skip_q) begin
            // Orphaned y byte of a dropped packet: swallow it silently.
            skip_d = 1'b0;
            tmo_d  = '0;
          end else if (is_cfg) begin
            brush_d   = byteData[4];
            color_d   = byteData[2:0];
            cfg_upd_d = 1'b1;
          end else if (idle_rules) begin
            x_d     = byteData;
            tmo_d   = '0;
            state_d = ST_HAVE_X;
          end else begin
            // Position packet while a draw is still pending: drop it and
            // arrange to discard its y byte as well.
            drop_d = drop_inc;
            skip_d = 1'b1;
            tmo_d  = '0;
          end
        end else if (skip_q) begin
          // A missing y byte must not stall framing forever.
          if (tmo_hit) begin
            skip_d = 1'b0;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        draw_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= 8'd0;
      draw_req_q   <= 1'b0;
      draw_x_q     <= 8'd0;
      draw_y_q     <= 8'd0;
      draw_color_q <= DEFAULT_COLOR;
      draw_brush_q <= DEFAULT_BRUSH;
      color_q      <= DEFAULT_COLOR;
      brush_q      <= DEFAULT_BRUSH;
      cfg_upd_q    <= 1'b0;
      drop_q       <= 8'd0;
      skip_q       <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      draw_req_q   <= draw_req_d;
      draw_x_q     <= draw_x_d;
      draw_y_q     <= draw_y_d;
      draw_color_q <= draw_color_d;
      draw_brush_q <= draw_brush_d;
      color_q      <= color_d;
      brush_q      <= brush_d;
      cfg_upd_q    <= cfg_upd_d;
      drop_q       <= drop_d;
      skip_q       <= skip_d;
      tmo_q        <= tmo_d;
    end
  end

  assign drawReq       = draw_req_q;
  assign drawX         = draw_x_q;
  assign drawY         = draw_y_q;
  assign drawColor     = draw_color_q;
  assign drawBrush     = draw_brush_q;
  assign color         = color_q;
  assign brush         = brush_q;
  assign configUpdated = cfg_upd_q;
  assign dropCount     = drop_q;
  assign dbgState      = state_q;

endmodule

// File: tb/tb_spi_draw_sequencer.sv
module tb_spi_draw_sequencer;

  localparam int TMO = 16;

  logic       clk;
  logic       reset;
  logic       byteValid;
  logic [7:0] byteData;
  logic       drawAck;
  logic       drawReq;
  logic [7:0] drawX;
  logic [7:0] drawY;
  logic [2:0] drawColor;
  logic       drawBrush;
  logic [2:0] color;
  logic       brush;
  logic       configUpdated;
  logic [7:0] dropCount;
  logic [1:0] dbgState;

  int n_checks = 0;
  int n_errors = 0;

  spi_draw_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .DEFAULT_COLOR (3'b010),
    .DEFAULT_BRUSH (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .byteValid    (byteValid),
    .byteData     (byteData),
    .drawAck      (drawAck),
    .drawReq      (drawReq),
    .drawX        (drawX),
    .drawY        (drawY),
    .drawColor    (drawColor),
    .drawBrush    (drawBrush),
    .color        (color),
    .brush        (brush),
    .configUpdated(configUpdated),
    .dropCount    (dropCount),
    .dbgState     (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte for one edge; returns 1 unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    byteValid = 1'b1;
    byteData  = b;
    tick(1);
    byteValid = 1'b0;
    byteData  = 8'h00;
  endtask

  task automatic ack;
    drawAck = 1'b1;
    tick(1);
    drawAck = 1'b0;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    reset     = 1'b1;
    byteValid = 1'b0;
    byteData  = 8'h00;
    drawAck   = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // 1: reset values, basic packet and ack
    check("rst_req",    {31'd0, drawReq},       32'd0);
    check("rst_x",      {24'd0, drawX},         32'd0);
    check("rst_y",      {24'd0, drawY},         32'd0);
    check("rst_dcolor", {29'd0, drawColor},     32'd2);
    check("rst_dbrush", {31'd0, drawBrush},     32'd1);
    check("rst_color",  {29'd0, color},         32'd2);
    check("rst_brush",  {31'd0, brush},         32'd1);
    check("rst_cfgupd", {31'd0, configUpdated}, 32'd0);
    check("rst_drop",   {24'd0, dropCount},     32'd0);
    check("rst_state",  {30'd0, dbgState},      32'd0);
    send_byte(8'h05);
    check("t1_havex",   {30'd0, dbgState},      32'd1);
    check("t1_noreq",   {31'd0, drawReq},       32'd0);
    send_byte(8'h09);
    check("t1_req",     {31'd0, drawReq},       32'd1);
    check("t1_x",       {24'd0, drawX},         32'h05);
    check("t1_y",       {24'd0, drawY},         32'h09);
    check("t1_dcolor",  {29'd0, drawColor},     32'd2);
    check("t1_dbrush",  {31'd0, drawBrush},     32'd1);
    tick(3);
    check("t1_hold",    {31'd0, drawReq},       32'd1);
    ack();
    check("t1_ackreq",  {31'd0, drawReq},       32'd0);
    check("t1_idle",    {30'd0, dbgState},      32'd0);

    // 2: config bytes and a y byte that looks like config
    send_byte(8'hF3);
    check("t2_color",   {29'd0, color},         32'd3);
    check("t2_brush",   {31'd0, brush},         32'd1);
    check("t2_upd",     {31'd0, configUpdated}, 32'd1);
    tick(1);
    check("t2_upd_off", {31'd0, configUpdated}, 32'd0);
    send_byte(8'hE0);
    check("t2_color0",  {29'd0, color},         32'd0);
    check("t2_brush0",  {31'd0, brush},         32'd0);
    send_byte(8'h10);
    send_byte(8'hE7);
    check("t2_req",     {31'd0, drawReq},       32'd1);
    check("t2_x",       {24'd0, drawX},         32'h10);
    check("t2_y",       {24'd0, drawY},         32'hE7);
    check("t2_dcolor",  {29'd0, drawColor},     32'd0);
    check("t2_dbrush",  {31'd0, drawBrush},     32'd0);
    ack();

    // 3: timeout between x and y
    pulse_reset();
    send_byte(8'h20);
    tick(TMO - 1);
    check("t3_pre_tmo", {30'd0, dbgState},      32'd1);
    check("t3_pre_drop",{24'd0, dropCount},     32'd0);
    tick(1);
    check("t3_tmo_st",  {30'd0, dbgState},      32'd0);
    check("t3_tmo_drop",{24'd0, dropCount},     32'd1);
    check("t3_noreq",   {31'd0, drawReq},       32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    check("t3_req",     {31'd0, drawReq},       32'd1);
    check("t3_x",       {24'd0, drawX},         32'h01);
    check("t3_y",       {24'd0, drawY},         32'h02);
    ack();

    // 4: traffic while a request is pending
    pulse_reset();
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h07);
    check("t4_drop1",   {24'd0, dropCount},     32'd1);
    check("t4_x_hold",  {24'd0, drawX},         32'h03);
    send_byte(8'h08);
    check("t4_skip",    {24'd0, dropCount},     32'd1);
    check("t4_y_hold",  {24'd0, drawY},         32'h04);
    check("t4_st",      {30'd0, dbgState},      32'd2);
    send_byte(8'hF5);
    check("t4_color",   {29'd0, color},         32'd5);
    check("t4_upd",     {31'd0, configUpdated}, 32'd1);
    check("t4_dcolor",  {29'd0, drawColor},     32'd2);
    check("t4_req",     {31'd0, drawReq},       32'd1);
    ack();
    check("t4_ackreq",  {31'd0, drawReq},       32'd0);
    send_byte(8'h0A);
    send_byte(8'h0B);
    check("t4_x2",      {24'd0, drawX},         32'h0A);
    check("t4_y2",      {24'd0, drawY},         32'h0B);
    check("t4_dcolor2", {29'd0, drawColor},     32'd5);
    // Dropped packet whose y byte never arrives: skip expires unannounced.
    send_byte(8'h11);
    check("t4_drop2",   {24'd0, dropCount},     32'd2);
    ack();
    tick(TMO + 2);
    send_byte(8'h12);
    check("t4_skipexp", {30'd0, dbgState},      32'd1);
    check("t4_drop_eq", {24'd0, dropCount},     32'd2);
    send_byte(8'h13);
    ack();

    // 5: ack and new byte in the same cycle
    pulse_reset();
    send_byte(8'h01);
    send_byte(8'h02);
    drawAck = 1'b1;
    send_byte(8'h30);
    drawAck = 1'b0;
    check("t5_retire",  {31'd0, drawReq},       32'd0);
    check("t5_havex",   {30'd0, dbgState},      32'd1);
    send_byte(8'h31);
    check("t5_req",     {31'd0, drawReq},       32'd1);
    check("t5_x",       {24'd0, drawX},         32'h30);
    check("t5_y",       {24'd0, drawY},         32'h31);
    ack();

    // 6: drop counter saturation, then asynchronous reset mid-handshake
    pulse_reset();
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h40);
      tick(TMO);
      if (i == 253) check("t6_drop254", {24'd0, dropCount}, 32'd254);
    end
    check("t6_sat",     {24'd0, dropCount},     32'd255);
    send_byte(8'hF1);
    send_byte(8'h01);
    send_byte(8'h02);
    check("t6_req",     {31'd0, drawReq},       32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_areq",    {31'd0, drawReq},       32'd0);
    check("t6_ax",      {24'd0, drawX},         32'd0);
    check("t6_ay",      {24'd0, drawY},         32'd0);
    check("t6_adcolor", {29'd0, drawColor},     32'd2);
    check("t6_adbrush", {31'd0, drawBrush},     32'd1);
    check("t6_acolor",  {29'd0, color},         32'd2);
    check("t6_abrush",  {31'd0, brush},         32'd1);
    check("t6_adrop",   {24'd0, dropCount},     32'd0);
    check("t6_astate",  {30'd0, dbgState},      32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    check("t6_post_req",{31'd0, drawReq},       32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
